// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions for the DMA <-> accelerator stream path.
package axis_pkg;

  localparam int unsigned AXIS_DATA_W    = 32;
  localparam int unsigned DMA_FIFO_DEPTH = 16;

  // One buffered stream beat: last-of-frame flag above the data word.
  typedef struct packed {
    logic                   tlast;
    logic [AXIS_DATA_W-1:0] tdata;
  } axis_entry_t;

endpackage : axis_pkg

// File: rtl/axis_fifo_mem.sv
// Register-array storage for the stream FIFO: one write port, asynchronous read.
module axis_fifo_mem #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the accepted beat; contents carry no reset, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : axis_fifo_mem

// File: rtl/axis_dma_fifo.sv
// AXI-Stream buffer between the DMA stream master and the accelerator slave.
// Carries tdata/tlast, reports fill level and number of buffered frame ends.
// DEPTH must be a power of two and at least 2.
module axis_dma_fifo
  import axis_pkg::*;
#(
  parameter  int unsigned DATA_W = AXIS_DATA_W,
  parameter  int unsigned DEPTH  = DMA_FIFO_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [AW:0]       level,
  output logic [AW:0]       frames,
  output logic              frame_out
);

  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr_next;
  logic [PW-1:0]   rd_ptr_next;
  logic [PW-1:0]   level_next;
  logic [PW-1:0]   frames_next;
  logic            push;
  logic            pop;
  logic            push_last;
  logic            pop_last;
  logic [DATA_W:0] wdata;
  logic [DATA_W:0] rdata;

  // Handshakes use only registered ready/valid, so no input-to-output comb path exists.
  assign push      = s_tvalid && s_tready;
  assign pop       = m_tvalid && m_tready;
  assign push_last = push && s_tlast;
  assign pop_last  = pop && rdata[DATA_W];
  assign wdata     = {s_tlast, s_tdata};

  axis_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  // Next pointer, level and frame-count values for this cycle's handshakes.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    frames_next = frames;
    if (push) begin
      wr_ptr_next = wr_ptr + PW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr + PW'(1);
    end
    // Pointer MSB distinguishes full from empty, so the difference spans 0..DEPTH.
    level_next = wr_ptr_next - rd_ptr_next;
    case ({push_last, pop_last})
      2'b10:   frames_next = frames + PW'(1);
      2'b01:   frames_next = frames - PW'(1);
      default: frames_next = frames;
    endcase
  end

  // State and registered status/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frames    <= '0;
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      frame_out <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      level     <= level_next;
      frames    <= frames_next;
      s_tready  <= (level_next < PW'(DEPTH));
      m_tvalid  <= (level_next != '0);
      frame_out <= pop_last;
    end
  end

  // Head entry falls through from storage; forced to zero while nothing is valid.
  assign m_tdata = m_tvalid ? rdata[DATA_W-1:0] : '0;
  assign m_tlast = m_tvalid ? rdata[DATA_W]     : 1'b0;

  // Structural invariants of the buffer.
  a_level_range : assert property (@(posedge clk) disable iff (rst)
    level <= PW'(DEPTH));
  a_frames_le_level : assert property (@(posedge clk) disable iff (rst)
    frames <= level);
  a_level_ptrs : assert property (@(posedge clk) disable iff (rst)
    level == PW'(wr_ptr - rd_ptr));
  a_valid_level : assert property (@(posedge clk) disable iff (rst)
    m_tvalid == (level != '0));
  a_hold_m : assert property (@(posedge clk) disable iff (rst)
    (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_tdata) && $stable(m_tlast)));

endmodule : axis_dma_fifo

// File: tb/tb_axis_dma_fifo.sv
// Randomized self-checking bench for axis_dma_fifo against a queue-based model.
module tb_axis_dma_fifo;
  import axis_pkg::*;

  localparam int unsigned DW  = AXIS_DATA_W;
  localparam int unsigned DEP = DMA_FIFO_DEPTH;
  localparam int unsigned AW  = $clog2(DEP);

  logic          clk;
  logic          rst;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready;
  logic [AW:0]   level;
  logic [AW:0]   frames;
  logic          frame_out;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model: queue of beats plus the registered flags' expected values.
  axis_entry_t   q[$];
  logic          mdl_rdy;
  logic          mdl_fo;
  logic [DW-1:0] dut_out[$];

  axis_dma_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .level     (level),
    .frames    (frames),
    .frame_out (frame_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mdl_frames();
    int n = 0;
    foreach (q[i]) if (q[i].tlast) n++;
    return n;
  endfunction

  // Advance model and DUT one clock; inputs are whatever the caller has driven.
  task automatic tick();
    logic push;
    logic pop;
    if (rst) begin
      q.delete();
      mdl_rdy = 1'b0;
      mdl_fo  = 1'b0;
    end else begin
      push   = s_tvalid && mdl_rdy;
      pop    = (q.size() > 0) && m_tready;
      mdl_fo = 1'b0;
      if (pop) begin
        dut_out.push_back(m_tdata);
        mdl_fo = q[0].tlast;
        void'(q.pop_front());
      end
      if (push) q.push_back('{tlast: s_tlast, tdata: s_tdata});
      mdl_rdy = (q.size() < DEP);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    tick(); tick();
    chk_cnt++; if (level !== '0) $display("FAIL reset_level: got %0d want 0", level); else pass_cnt++;
    chk_cnt++; if (frames !== '0) $display("FAIL reset_frames: got %0d want 0", frames); else pass_cnt++;
    chk_cnt++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); else pass_cnt++;
    chk_cnt++; if (s_tready !== 1'b0) $display("FAIL reset_s_tready: got %b want 0", s_tready); else pass_cnt++;
    chk_cnt++; if (frame_out !== 1'b0) $display("FAIL reset_frame_out: got %b want 0", frame_out); else pass_cnt++;
    rst = 1'b0;
    tick();
    chk_cnt++; if (s_tready !== 1'b1) $display("FAIL release_s_tready: got %b want 1", s_tready); else pass_cnt++;
  endtask

  task automatic test_single();
    s_tvalid = 1'b1; s_tdata = 32'hDEADBEEF; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk_cnt++; if (m_tvalid !== 1'b1) $display("FAIL single_valid: got %b want 1", m_tvalid); else pass_cnt++;
    chk_cnt++; if (m_tdata !== 32'hDEADBEEF) $display("FAIL single_data: got %h want deadbeef", m_tdata); else pass_cnt++;
    chk_cnt++; if (m_tlast !== 1'b1) $display("FAIL single_last: got %b want 1", m_tlast); else pass_cnt++;
    chk_cnt++; if (level !== 5'd1) $display("FAIL single_level: got %0d want 1", level); else pass_cnt++;
    chk_cnt++; if (frames !== 5'd1) $display("FAIL single_frames: got %0d want 1", frames); else pass_cnt++;
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    chk_cnt++; if (frame_out !== 1'b1) $display("FAIL single_frame_out: got %b want 1", frame_out); else pass_cnt++;
    chk_cnt++; if (level !== 5'd0) $display("FAIL single_level_pop: got %0d want 0", level); else pass_cnt++;
    chk_cnt++; if (frames !== 5'd0) $display("FAIL single_frames_pop: got %0d want 0", frames); else pass_cnt++;
    chk_cnt++; if (m_tvalid !== 1'b0) $display("FAIL single_valid_pop: got %b want 0", m_tvalid); else pass_cnt++;
    tick();
    chk_cnt++; if (frame_out !== 1'b0) $display("FAIL single_pulse_width: got %b want 0", frame_out); else pass_cnt++;
    dut_out.delete();
  endtask

  task automatic test_fill();
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(i); s_tlast = (i == 15);
      tick();
    end
    chk_cnt++; if (s_tready !== 1'b0) $display("FAIL fill_s_tready: got %b want 0", s_tready); else pass_cnt++;
    chk_cnt++; if (level !== 5'd16) $display("FAIL fill_level: got %0d want 16", level); else pass_cnt++;
    chk_cnt++; if (frames !== 5'd1) $display("FAIL fill_frames: got %0d want 1", frames); else pass_cnt++;
    s_tdata = 32'h99; s_tlast = 1'b0;
    tick();
    chk_cnt++; if (level !== 5'd16) $display("FAIL fill_17th_level: got %0d want 16", level); else pass_cnt++;
    chk_cnt++; if (m_tdata !== 32'd0) $display("FAIL fill_head: got %h want 0", m_tdata); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    int guard;
    s_tvalid = 1'b1; s_tdata = 32'h99; s_tlast = 1'b0; m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    chk_cnt++; if (level !== 5'd15) $display("FAIL full_pop_level: got %0d want 15", level); else pass_cnt++;
    chk_cnt++; if (s_tready !== 1'b1) $display("FAIL full_pop_s_tready: got %b want 1", s_tready); else pass_cnt++;
    chk_cnt++; if (dut_out.size() != 1 || dut_out[0] !== 32'd0)
      $display("FAIL full_pop_value: got %0d beats want value 0", dut_out.size()); else pass_cnt++;
    chk_cnt++; if (m_tdata !== 32'd1) $display("FAIL full_pop_next_head: got %h want 1", m_tdata); else pass_cnt++;
    s_tvalid = 1'b0; m_tready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      chk_cnt++; if (m_tdata !== q[0].tdata) $display("FAIL drain_data: got %h want %h", m_tdata, q[0].tdata); else pass_cnt++;
      tick(); guard++;
    end
    m_tready = 1'b0;
    chk_cnt++; if (level !== 5'd0) $display("FAIL drain_level: got %0d want 0", level); else pass_cnt++;
    dut_out.delete();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] sent[$];
    int guard;
    m_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_tvalid = 1'b1; s_tdata = $urandom(); s_tlast = (i % 8 == 7);
      sent.push_back(s_tdata);
      tick();
      chk_cnt++; if (level !== 5'd1) $display("FAIL stream_level: got %0d want 1 at %0d", level, i); else pass_cnt++;
      chk_cnt++; if (s_tready !== 1'b1) $display("FAIL stream_s_tready: got %b want 1 at %0d", s_tready, i); else pass_cnt++;
    end
    s_tvalid = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 50) begin tick(); guard++; end
    chk_cnt++; if (dut_out.size() != 40) $display("FAIL stream_count: got %0d want 40", dut_out.size()); else pass_cnt++;
    for (int i = 0; i < 40 && i < dut_out.size(); i++) begin
      chk_cnt++; if (dut_out[i] !== sent[i]) $display("FAIL stream_order: got %h want %h at %0d", dut_out[i], sent[i], i); else pass_cnt++;
    end
    m_tready = 1'b0;
    dut_out.delete();
  endtask

  task automatic test_random();
    int sent_n = 0;
    int fo_cnt = 0;
    int cyc    = 0;
    s_tvalid = 1'b0;
    while ((sent_n < 1000 || q.size() > 0) && cyc < 20000) begin
      if (!(s_tvalid && !mdl_rdy)) begin
        if (sent_n < 1000 && $urandom_range(1, 0) == 1) begin
          s_tvalid = 1'b1; s_tdata = $urandom(); s_tlast = (sent_n % 8 == 7);
        end else begin
          s_tvalid = 1'b0;
        end
      end
      m_tready = ($urandom_range(1, 0) == 1);
      if (s_tvalid && mdl_rdy) sent_n++;
      tick(); cyc++;
      if (frame_out === 1'b1) fo_cnt++;
      chk_cnt++; if (level !== (AW+1)'(q.size())) $display("FAIL rnd_level: got %0d want %0d", level, q.size()); else pass_cnt++;
      chk_cnt++; if (frames !== (AW+1)'(mdl_frames())) $display("FAIL rnd_frames: got %0d want %0d", frames, mdl_frames()); else pass_cnt++;
      chk_cnt++; if (s_tready !== mdl_rdy) $display("FAIL rnd_s_tready: got %b want %b", s_tready, mdl_rdy); else pass_cnt++;
      chk_cnt++; if (m_tvalid !== (q.size() > 0)) $display("FAIL rnd_m_tvalid: got %b want %b", m_tvalid, q.size() > 0); else pass_cnt++;
      chk_cnt++; if (frame_out !== mdl_fo) $display("FAIL rnd_frame_out: got %b want %b", frame_out, mdl_fo); else pass_cnt++;
      chk_cnt++; if (frames > level) $display("FAIL rnd_frames_le_level: got %0d want <= %0d", frames, level); else pass_cnt++;
      if (q.size() > 0) begin
        chk_cnt++; if ({m_tlast, m_tdata} !== q[0]) $display("FAIL rnd_head: got %h want %h", {m_tlast, m_tdata}, q[0]); else pass_cnt++;
      end
      if (sent_n >= 1000 && s_tvalid && mdl_rdy) s_tvalid = 1'b0;
    end
    s_tvalid = 1'b0; m_tready = 1'b0;
    chk_cnt++; if (cyc >= 20000) $display("FAIL rnd_timeout: got %0d cycles want < 20000", cyc); else pass_cnt++;
    chk_cnt++; if (fo_cnt != 125) $display("FAIL rnd_frame_out_count: got %0d want 125", fo_cnt); else pass_cnt++;
    chk_cnt++; if (dut_out.size() != 1000) $display("FAIL rnd_pop_count: got %0d want 1000", dut_out.size()); else pass_cnt++;
    dut_out.delete();
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(32'h100 + i); s_tlast = (i == 2);
      tick();
    end
    s_tvalid = 1'b0;
    chk_cnt++; if (level !== 5'd5) $display("FAIL mid_pre_level: got %0d want 5", level); else pass_cnt++;
    rst = 1'b1;
    tick();
    chk_cnt++; if (level !== 5'd0) $display("FAIL mid_level: got %0d want 0", level); else pass_cnt++;
    chk_cnt++; if (frames !== 5'd0) $display("FAIL mid_frames: got %0d want 0", frames); else pass_cnt++;
    chk_cnt++; if (m_tvalid !== 1'b0) $display("FAIL mid_m_tvalid: got %b want 0", m_tvalid); else pass_cnt++;
    chk_cnt++; if (s_tready !== 1'b0) $display("FAIL mid_s_tready: got %b want 0", s_tready); else pass_cnt++;
    rst = 1'b0;
    tick();
    s_tvalid = 1'b1; s_tdata = 32'hA5A5_5A5A; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk_cnt++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hA5A5_5A5A)
      $display("FAIL mid_first_word: got %b/%h want 1/a5a55a5a", m_tvalid, m_tdata); else pass_cnt++;
    chk_cnt++; if (level !== 5'd1) $display("FAIL mid_post_level: got %0d want 1", level); else pass_cnt++;
  endtask

  initial begin
    mdl_rdy = 1'b0;
    mdl_fo  = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_axis_dma_fifo
